// File: rtl/dcache_nway_tag_array.sv
// N-way set-associative tag store for the dcache.
// Holds valid/dirty/tag per way, answers lookups one cycle later with hit way and a
// replacement victim (first invalid way, else tree-PLRU), accepts single-entry updates and
// runs a flush walker that presents every valid+dirty line for writeback and then
// invalidates the whole array.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   lookup_*               lookup request (set index + tag); lookup_ready_o low while flushing
//   rsp_*                  registered lookup response: hit, one-hot hit way, victim info
//   update_*               write valid/dirty/tag of one (set, one-hot way) entry
//   flush_req_i/busy_o     start flush / walker active
//   flush_line_*, flush_*  dirty line handshake (index, one-hot way, tag), done pulse
module dcache_nway_tag_array #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned SETS  = 64,
  parameter int unsigned TAG_W = 22,
  localparam int unsigned IDX_W = $clog2(SETS),
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             lookup_req_i,
  output logic             lookup_ready_o,
  input  logic [IDX_W-1:0] lookup_index_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             rsp_valid_o,
  output logic             rsp_hit_o,
  output logic [WAYS-1:0]  rsp_hit_way_o,
  output logic [WAYS-1:0]  rsp_victim_way_o,
  output logic             rsp_victim_valid_o,
  output logic             rsp_victim_dirty_o,
  output logic [TAG_W-1:0] rsp_victim_tag_o,
  input  logic             update_req_i,
  input  logic [IDX_W-1:0] update_index_i,
  input  logic [WAYS-1:0]  update_way_i,
  input  logic             update_valid_i,
  input  logic             update_dirty_i,
  input  logic [TAG_W-1:0] update_tag_i,
  input  logic             flush_req_i,
  output logic             flush_busy_o,
  output logic             flush_line_valid_o,
  input  logic             flush_line_ready_i,
  output logic [IDX_W-1:0] flush_index_o,
  output logic [WAYS-1:0]  flush_way_o,
  output logic [TAG_W-1:0] flush_tag_o,
  output logic             flush_done_o
);

  localparam int unsigned LVL    = $clog2(WAYS);
  localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {StIdle, StScan, StEmit, StDone} flush_state_e;

  // PLRU tree stored heap-style: node n has children 2n+1 (lower half) and 2n+2.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    int unsigned node;
    node = 0;
    for (int unsigned l = 0; l < LVL; l++) begin
      node = bits[node] ? 2 * node + 2 : 2 * node + 1;
    end
    return WAY_W'(node - (WAYS - 1));
  endfunction

  // Point every node on the path to 'way' towards the other subtree.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [PLRU_W-1:0] res;
    int unsigned node;
    res  = bits;
    node = 0;
    for (int unsigned l = 0; l < LVL; l++) begin
      if (way[LVL-1-l]) begin
        res[node] = 1'b0;
        node      = 2 * node + 2;
      end else begin
        res[node] = 1'b1;
        node      = 2 * node + 1;
      end
    end
    return res;
  endfunction

  function automatic logic [WAY_W-1:0] onehot_to_idx(input logic [WAYS-1:0] oh);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (oh[w]) idx = WAY_W'(w);
    end
    return idx;
  endfunction

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [PLRU_W-1:0] plru_q  [SETS];

  flush_state_e      state_q, state_d;
  logic [IDX_W-1:0]  fl_set_q;
  logic [WAY_W-1:0]  fl_way_q;
  logic              fl_clear, fl_adv, fl_last, fl_entry_vd;

  logic              lookup_fire, hit;
  logic [WAY_W-1:0]  hit_idx, vict_idx;
  logic              any_inv;
  logic              upd_en, upd_touch, hit_touch;
  logic [WAY_W-1:0]  upd_idx;

  logic              rsp_valid_q, rsp_hit_q, rsp_vvalid_q, rsp_vdirty_q;
  logic [WAYS-1:0]   rsp_hit_way_q, rsp_vway_q;
  logic [TAG_W-1:0]  rsp_vtag_q;

  assign lookup_ready_o = (state_q == StIdle);
  assign flush_busy_o   = (state_q != StIdle);
  assign lookup_fire    = lookup_req_i & lookup_ready_o;

  assign upd_idx   = onehot_to_idx(update_way_i);
  assign upd_en    = update_req_i & ($countones(update_way_i) == 1) & ~flush_busy_o;
  assign upd_touch = upd_en & update_valid_i;
  assign hit_touch = lookup_fire & hit;

  // Compare against the current array contents; an update in the same cycle is not visible.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    any_inv  = 1'b0;
    vict_idx = plru_victim(plru_q[lookup_index_i]);
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[lookup_index_i][w] && (tag_q[lookup_index_i][w] == lookup_tag_i)) begin
        hit     = 1'b1;
        hit_idx = WAY_W'(w);
      end
      if (!any_inv && !valid_q[lookup_index_i][w]) begin
        any_inv  = 1'b1;
        vict_idx = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q   <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_hit_way_q <= '0;
      rsp_vway_q    <= '0;
      rsp_vvalid_q  <= 1'b0;
      rsp_vdirty_q  <= 1'b0;
      rsp_vtag_q    <= '0;
    end else begin
      rsp_valid_q <= lookup_fire;
      if (lookup_fire) begin
        rsp_hit_q     <= hit;
        rsp_hit_way_q <= hit ? (WAYS'(1) << hit_idx) : '0;
        rsp_vway_q    <= WAYS'(1) << vict_idx;
        rsp_vvalid_q  <= valid_q[lookup_index_i][vict_idx];
        rsp_vdirty_q  <= dirty_q[lookup_index_i][vict_idx];
        rsp_vtag_q    <= tag_q[lookup_index_i][vict_idx];
      end
    end
  end

  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_hit_o          = rsp_hit_q;
  assign rsp_hit_way_o      = rsp_hit_way_q;
  assign rsp_victim_way_o   = rsp_vway_q;
  assign rsp_victim_valid_o = rsp_vvalid_q;
  assign rsp_victim_dirty_o = rsp_vdirty_q;
  assign rsp_victim_tag_o   = rsp_vtag_q;

  // Tags carry no reset; they are meaningless while the valid bit is clear.
  always_ff @(posedge clk_i) begin
    if (upd_en) tag_q[update_index_i][upd_idx] <= update_tag_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      if (upd_en) begin
        valid_q[update_index_i][upd_idx] <= update_valid_i;
        dirty_q[update_index_i][upd_idx] <= update_dirty_i;
      end
      if (fl_clear) begin
        valid_q[fl_set_q][fl_way_q] <= 1'b0;
        dirty_q[fl_set_q][fl_way_q] <= 1'b0;
      end
    end
  end

  // Update touch is issued last so it overrides a hit touch on the same set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (state_q == StDone) begin
      for (int unsigned s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      if (hit_touch) plru_q[lookup_index_i] <= plru_touch(plru_q[lookup_index_i], hit_idx);
      if (upd_touch) plru_q[update_index_i] <= plru_touch(plru_q[update_index_i], upd_idx);
    end
  end

  assign fl_entry_vd = valid_q[fl_set_q][fl_way_q] & dirty_q[fl_set_q][fl_way_q];
  assign fl_last     = (fl_set_q == IDX_W'(SETS - 1)) && (fl_way_q == WAY_W'(WAYS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      fl_set_q <= '0;
      fl_way_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle) begin
        fl_set_q <= '0;
        fl_way_q <= '0;
      end else if (fl_adv) begin
        if (fl_way_q == WAY_W'(WAYS - 1)) begin
          fl_way_q <= '0;
          fl_set_q <= fl_set_q + 1'b1;
        end else begin
          fl_way_q <= fl_way_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    fl_clear           = 1'b0;
    fl_adv             = 1'b0;
    flush_line_valid_o = 1'b0;
    flush_done_o       = 1'b0;
    flush_index_o      = '0;
    flush_way_o        = '0;
    flush_tag_o        = '0;
    unique case (state_q)
      StIdle: begin
        if (flush_req_i) state_d = StScan;
      end
      StScan: begin
        if (fl_entry_vd) begin
          state_d = StEmit;
        end else begin
          fl_clear = 1'b1;
          fl_adv   = 1'b1;
          if (fl_last) state_d = StDone;
        end
      end
      StEmit: begin
        flush_line_valid_o = 1'b1;
        flush_index_o      = fl_set_q;
        flush_way_o        = WAYS'(1) << fl_way_q;
        flush_tag_o        = tag_q[fl_set_q][fl_way_q];
        if (flush_line_ready_i) begin
          fl_clear = 1'b1;
          fl_adv   = 1'b1;
          state_d  = fl_last ? StDone : StScan;
        end
      end
      StDone: begin
        flush_done_o = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_dcache_nway_tag_array.sv
// Self-checking bench for dcache_nway_tag_array: directed scenarios plus randomized
// lookup/update traffic and flushes, checked against a timestamp-based reference model.
module tb_dcache_nway_tag_array;

  localparam int WAYS  = 4;
  localparam int SETS  = 64;
  localparam int TAG_W = 22;
  localparam int IDX_W = 6;

  logic             clk, rst_n;
  logic             lookup_req, lookup_ready;
  logic [IDX_W-1:0] lookup_index;
  logic [TAG_W-1:0] lookup_tag;
  logic             rsp_valid, rsp_hit, rsp_victim_valid, rsp_victim_dirty;
  logic [WAYS-1:0]  rsp_hit_way, rsp_victim_way;
  logic [TAG_W-1:0] rsp_victim_tag;
  logic             update_req, update_valid, update_dirty;
  logic [IDX_W-1:0] update_index;
  logic [WAYS-1:0]  update_way;
  logic [TAG_W-1:0] update_tag;
  logic             flush_req, flush_busy, flush_line_valid, flush_line_ready, flush_done;
  logic [IDX_W-1:0] flush_index;
  logic [WAYS-1:0]  flush_way;
  logic [TAG_W-1:0] flush_tag;

  dcache_nway_tag_array #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lookup_req_i(lookup_req), .lookup_ready_o(lookup_ready),
    .lookup_index_i(lookup_index), .lookup_tag_i(lookup_tag),
    .rsp_valid_o(rsp_valid), .rsp_hit_o(rsp_hit), .rsp_hit_way_o(rsp_hit_way),
    .rsp_victim_way_o(rsp_victim_way), .rsp_victim_valid_o(rsp_victim_valid),
    .rsp_victim_dirty_o(rsp_victim_dirty), .rsp_victim_tag_o(rsp_victim_tag),
    .update_req_i(update_req), .update_index_i(update_index), .update_way_i(update_way),
    .update_valid_i(update_valid), .update_dirty_i(update_dirty), .update_tag_i(update_tag),
    .flush_req_i(flush_req), .flush_busy_o(flush_busy),
    .flush_line_valid_o(flush_line_valid), .flush_line_ready_i(flush_line_ready),
    .flush_index_o(flush_index), .flush_way_o(flush_way), .flush_tag_o(flush_tag),
    .flush_done_o(flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Reference model: per-entry state plus last-touch timestamps (0 = never touched).
  // A tree node points to the half whose most recent touch is older.
  bit               mv [SETS][WAYS];
  bit               md [SETS][WAYS];
  logic [TAG_W-1:0] mt [SETS][WAYS];
  int unsigned      ts [SETS][WAYS];
  int unsigned      now_t = 0;

  function automatic void model_invalidate_all();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 1'b0;
        md[s][w] = 1'b0;
        ts[s][w] = 0;
      end
    end
  endfunction

  function automatic void model_touch(input int s, input int w);
    now_t++;
    ts[s][w] = now_t;
  endfunction

  function automatic int model_victim(input int s);
    int lo, size, half;
    int unsigned ml, mr;
    for (int w = 0; w < WAYS; w++) if (!mv[s][w]) return w;
    lo   = 0;
    size = WAYS;
    while (size > 1) begin
      half = size / 2;
      ml   = 0;
      mr   = 0;
      for (int i = 0; i < half; i++) begin
        if (ts[s][lo+i] > ml) ml = ts[s][lo+i];
        if (ts[s][lo+half+i] > mr) mr = ts[s][lo+half+i];
      end
      if (ml > mr) lo += half;
      size = half;
    end
    return lo;
  endfunction

  logic            last_hit, last_vvalid;
  logic [WAYS-1:0] last_hit_way, last_vway;

  // One clock cycle with optional lookup and update, checked against the model.
  task automatic cycle(input bit lreq, input int lidx, input logic [TAG_W-1:0] ltag,
                       input bit ureq, input int uidx, input logic [WAYS-1:0] uway,
                       input bit uv, input bit ud, input logic [TAG_W-1:0] utag);
    int hw, vw, uw;
    bit uok;
    @(negedge clk);
    lookup_req   = lreq;
    lookup_index = IDX_W'(lidx);
    lookup_tag   = ltag;
    update_req   = ureq;
    update_index = IDX_W'(uidx);
    update_way   = uway;
    update_valid = uv;
    update_dirty = ud;
    update_tag   = utag;
    hw = -1;
    for (int w = 0; w < WAYS; w++) if (hw < 0 && mv[lidx][w] && mt[lidx][w] == ltag) hw = w;
    vw  = model_victim(lidx);
    uok = ureq && ($countones(uway) == 1);
    uw  = 0;
    for (int w = 0; w < WAYS; w++) if (uway[w]) uw = w;
    @(posedge clk);
    #1;
    lookup_req = 1'b0;
    update_req = 1'b0;
    check_eq("rsp_valid", rsp_valid, lreq);
    if (lreq) begin
      check_eq("rsp_hit", rsp_hit, hw >= 0);
      check_eq("rsp_hit_way", rsp_hit_way, (hw >= 0) ? (64'd1 << hw) : 64'd0);
      check_eq("rsp_victim_way", rsp_victim_way, 64'd1 << vw);
      check_eq("rsp_victim_valid", rsp_victim_valid, mv[lidx][vw]);
      check_eq("rsp_victim_dirty", rsp_victim_dirty, md[lidx][vw]);
      if (mv[lidx][vw]) check_eq("rsp_victim_tag", rsp_victim_tag, mt[lidx][vw]);
      last_hit     = rsp_hit;
      last_hit_way = rsp_hit_way;
      last_vway    = rsp_victim_way;
      last_vvalid  = rsp_victim_valid;
    end
    if (lreq && hw >= 0 && !(uok && uv && uidx == lidx)) model_touch(lidx, hw);
    if (uok) begin
      mv[uidx][uw] = uv;
      md[uidx][uw] = ud;
      mt[uidx][uw] = utag;
      if (uv) model_touch(uidx, uw);
    end
  endtask

  task automatic lookup(input int idx, input logic [TAG_W-1:0] tag);
    cycle(1'b1, idx, tag, 1'b0, 0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic update(input int idx, input logic [WAYS-1:0] way, input bit v, input bit d,
                        input logic [TAG_W-1:0] tag);
    cycle(1'b0, 0, '0, 1'b1, idx, way, v, d, tag);
  endtask

  // Run a flush. hold >= 0: consumer stalls 'hold' cycles per line; hold < 0: random ready.
  task automatic do_flush(input int hold, input bit check_timing, output int nlines);
    int q_set[$];
    int q_way[$];
    logic [TAG_W-1:0] q_tag[$];
    int n, waits;
    bit done, rdy;
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (mv[s][w] && md[s][w]) begin
          q_set.push_back(s);
          q_way.push_back(w);
          q_tag.push_back(mt[s][w]);
        end
      end
    end
    nlines = 0;
    @(negedge clk);
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    n     = 0;
    waits = 0;
    done  = 1'b0;
    while (!done && n < 4 * SETS * WAYS + 100) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check_eq("flush_busy", flush_busy, 1);
        check_eq("flush_lookup_ready", lookup_ready, 0);
      end
      if (flush_done) begin
        done = 1'b1;
        check_eq("flush_lines_left", q_set.size(), 0);
        if (check_timing) check_eq("flush_clean_cycles", n, SETS * WAYS + 1);
        flush_line_ready = 1'b0;
      end else if (flush_line_valid) begin
        if (q_set.size() == 0) begin
          check_eq("flush_extra_line", flush_line_valid, 0);
          flush_line_ready = 1'b1;
        end else begin
          check_eq("flush_index", flush_index, q_set[0]);
          check_eq("flush_way", flush_way, 64'd1 << q_way[0]);
          check_eq("flush_tag", flush_tag, q_tag[0]);
          rdy = (hold >= 0) ? (waits >= hold) : ($urandom_range(0, 2) != 0);
          flush_line_ready = rdy;
          if (rdy) begin
            void'(q_set.pop_front());
            void'(q_way.pop_front());
            void'(q_tag.pop_front());
            nlines++;
            waits = 0;
          end else begin
            waits++;
          end
        end
      end else begin
        flush_line_ready = 1'b0;
      end
    end
    check_eq("flush_done_seen", done, 1);
    @(posedge clk);
    #1;
    check_eq("flush_idle_after", flush_busy, 0);
    check_eq("flush_ready_after", lookup_ready, 1);
    model_invalidate_all();
  endtask

  task automatic random_traffic(input int n);
    logic [WAYS-1:0] uway;
    for (int i = 0; i < n; i++) begin
      uway = WAYS'(1) << $urandom_range(0, WAYS - 1);
      if ($urandom_range(0, 9) == 0) uway = WAYS'($urandom_range(0, 15));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3), TAG_W'($urandom_range(0, 5)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 3), uway,
            $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
            TAG_W'($urandom_range(0, 5)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int nl;
    bit seen;
    rst_n = 1'b0;
    lookup_req = 1'b0; lookup_index = '0; lookup_tag = '0;
    update_req = 1'b0; update_index = '0; update_way = '0;
    update_valid = 1'b0; update_dirty = 1'b0; update_tag = '0;
    flush_req = 1'b0; flush_line_ready = 1'b0;
    model_invalidate_all();
    repeat (2) @(negedge clk);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_lookup_ready", lookup_ready, 1);
    check_eq("rst_flush_busy", flush_busy, 0);
    check_eq("rst_flush_line_valid", flush_line_valid, 0);
    check_eq("rst_flush_way", flush_way, 0);
    check_eq("rst_victim_way", rsp_victim_way, 0);
    rst_n = 1'b1;

    lookup(5, 22'h1234);
    check_eq("d1_hit", last_hit, 0);
    check_eq("d1_victim", last_vway, 4'b0001);
    check_eq("d1_victim_valid", last_vvalid, 0);
    update(5, 4'b0100, 1'b1, 1'b0, 22'h1234);
    lookup(5, 22'h1234);
    check_eq("d2_hit", last_hit, 1);
    check_eq("d2_hit_way", last_hit_way, 4'b0100);
    lookup(5, 22'h1235);
    check_eq("d2_miss_victim", last_vway, 4'b0001);

    for (int w = 0; w < WAYS; w++) update(3, WAYS'(1) << w, 1'b1, 1'b0, TAG_W'(16 + w));
    lookup(3, 22'h10);
    lookup(3, 22'h99);
    check_eq("d3_victim_a", last_vway, 4'b0100);
    lookup(3, 22'h12);
    lookup(3, 22'h99);
    check_eq("d3_victim_b", last_vway, 4'b0010);

    cycle(1'b1, 7, 22'hAB, 1'b1, 7, 4'b0010, 1'b1, 1'b0, 22'hAB);
    check_eq("d4_same_cycle_hit", last_hit, 0);
    lookup(7, 22'hAB);
    check_eq("d4_hit_way", last_hit_way, 4'b0010);

    update(0, 4'b1000, 1'b1, 1'b1, 22'h3A);
    update(63, 4'b0001, 1'b1, 1'b1, 22'h3F);
    do_flush(3, 1'b0, nl);
    check_eq("d5_flush_lines", nl, 2);
    lookup(0, 22'h3A);
    check_eq("d5_after_flush_hit", last_hit, 0);
    do_flush(0, 1'b1, nl);

    random_traffic(500);
    do_flush(-1, 1'b0, nl);
    random_traffic(100);
    do_flush(-1, 1'b0, nl);

    // Reset while a line is being presented.
    update(10, 4'b0001, 1'b1, 1'b1, 22'h55);
    @(negedge clk);
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2 * SETS * WAYS && !seen; i++) begin
      @(negedge clk);
      seen = flush_line_valid;
    end
    check_eq("rst_emit_seen", seen, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_line_valid", flush_line_valid, 0);
    check_eq("rst_mid_busy", flush_busy, 0);
    check_eq("rst_mid_ready", lookup_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_invalidate_all();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | flush_done;
    end
    check_eq("rst_mid_no_done", seen, 0);
    lookup(10, 22'h55);
    check_eq("rst_mid_miss", last_hit, 0);
    random_traffic(50);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
